// File: rtl/touch_pkg.sv
// Shared encodings for the touch-controller SPI responder: FSM states, channel codes, frame lengths.
package touch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } touch_state_e;

  localparam logic [2:0] CH_X  = 3'b101;
  localparam logic [2:0] CH_Y  = 3'b001;
  localparam logic [2:0] CH_Z1 = 3'b011;
  localparam logic [2:0] CH_Z2 = 3'b100;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned DATA_CLKS = 16;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI line; rise/fall pulses come from the last two stages.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  =  sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  assign fall  = ~sync_q[SYNC_STAGES-2] &  sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/touch_spi_responder.sv
// Mode-0 SPI slave emulating an ADS7846-style touch controller: decodes command bytes and
// returns the selected sample MSB first after a busy slot.
module touch_spi_responder
  import touch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 12
) (
  input  logic              FAB_CLK,
  input  logic              MSS_RESET_N,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] x_pos,
  input  logic [DATA_W-1:0] y_pos,
  input  logic [DATA_W-1:0] z1_val,
  input  logic [DATA_W-1:0] z2_val,
  input  logic              pen_down,
  output logic              pen_irq_n,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync, pen_sync;
  logic mosi_lvl, pen_lvl;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(FAB_CLK), .rst_n(MSS_RESET_N), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(FAB_CLK), .rst_n(MSS_RESET_N), .din(spi_ss_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge FAB_CLK) begin
    if (!MSS_RESET_N) begin
      mosi_sync <= '0;
      pen_sync  <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      pen_sync  <= {pen_sync[SYNC_STAGES-2:0], pen_down};
    end
  end

  assign mosi_lvl = mosi_sync[SYNC_STAGES-1];
  assign pen_lvl  = pen_sync[SYNC_STAGES-1];

  touch_state_e      state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              mode_q, mode_d;
  logic [7:0]        cmd_byte_q, cmd_byte_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        pd_mode_q, pd_mode_d;
  logic              miso_q, miso_d;
  logic              pen_irq_n_q, pen_irq_n_d;

  logic [7:0]        cmd_full;
  logic [DATA_W-1:0] sample_sel;
  logic [4:0]        data_limit;
  logic              ss_abort;

  always_ff @(posedge FAB_CLK) begin
    if (!MSS_RESET_N) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      shadow_q    <= '0;
      mode_q      <= 1'b0;
      cmd_byte_q  <= '0;
      cmd_valid_q <= 1'b0;
      pd_mode_q   <= 2'b00;
      miso_q      <= 1'b0;
      pen_irq_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      shadow_q    <= shadow_d;
      mode_q      <= mode_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      pd_mode_q   <= pd_mode_d;
      miso_q      <= miso_d;
      pen_irq_n_q <= pen_irq_n_d;
    end
  end

  assign cmd_full   = {shift_q, mosi_lvl};
  assign data_limit = mode_q ? 5'd8 : 5'(DATA_W);
  // Select edges are included so a deassertion already seen in the synchronizer wins over a coincident SCLK edge.
  assign ss_abort   = ss_lvl | ss_rise | ss_fall;

  always_comb begin
    case (cmd_full[6:4])
      CH_X:    sample_sel = x_pos;
      CH_Y:    sample_sel = y_pos;
      CH_Z1:   sample_sel = z1_val;
      CH_Z2:   sample_sel = z2_val;
      default: sample_sel = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    shadow_d    = shadow_q;
    mode_d      = mode_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    pd_mode_d   = pd_mode_q;
    miso_d      = miso_q;
    pen_irq_n_d = (pd_mode_q == 2'b00 && state_q != ST_DATA) ? ~pen_lvl : 1'b1;

    if (ss_abort) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (sclk_rise && mosi_lvl) begin
            state_d   = ST_CMD;
            bit_cnt_d = 5'd1;
            shift_d   = 7'd1;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[5:0], mosi_lvl};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
              cmd_byte_d  = cmd_full;
              cmd_valid_d = 1'b1;
              pd_mode_d   = cmd_full[1:0];
              mode_d      = cmd_full[3];
              shadow_d    = sample_sel;
              state_d     = ST_DATA;
              bit_cnt_d   = '0;
            end
          end
        end
        ST_DATA: begin
          // bit_cnt counts data rises, so the fall being served is number bit_cnt+1.
          if (sclk_fall) begin
            if (bit_cnt_q >= 5'd1 && bit_cnt_q <= data_limit) begin
              miso_d   = shadow_q[DATA_W-1];
              shadow_d = shadow_q << 1;
            end else begin
              miso_d = 1'b0;
            end
          end else if (sclk_rise) begin
            if (bit_cnt_q == 5'(DATA_CLKS - 1)) begin
              state_d   = ST_IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign spi_miso_oe = ~ss_lvl;
  assign spi_miso    = miso_q & ~ss_lvl;
  assign pen_irq_n   = pen_irq_n_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;

endmodule

// File: tb/tb_touch_spi_responder.sv
// Directed bench for touch_spi_responder: acts as the SPI master, expected MISO bits come from a queue.
module tb_touch_spi_responder;

  logic        FAB_CLK = 1'b0;
  logic        MSS_RESET_N;
  logic        spi_sclk, spi_ss_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [11:0] x_pos, y_pos, z1_val, z2_val;
  logic        pen_down;
  logic        pen_irq_n, cmd_valid;
  logic [7:0]  cmd_byte;

  int unsigned n_tests = 0;
  int unsigned n_fails = 0;
  int unsigned cv_cnt  = 0;
  bit          exp_q[$];

  always #5 FAB_CLK = ~FAB_CLK;

  touch_spi_responder #(.SYNC_STAGES(2), .DATA_W(12)) dut (
    .FAB_CLK(FAB_CLK), .MSS_RESET_N(MSS_RESET_N),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .x_pos(x_pos), .y_pos(y_pos), .z1_val(z1_val), .z2_val(z2_val),
    .pen_down(pen_down), .pen_irq_n(pen_irq_n),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte)
  );

  always @(negedge FAB_CLK) if (cmd_valid === 1'b1) cv_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of the response word: busy slot, then 12 (or top 8) sample bits, then zeros.
  task automatic push_expected(input logic [11:0] val, input bit mode8, input int n);
    int nbits;
    nbits = mode8 ? 8 : 12;
    for (int i = 0; i < n; i++) begin
      if (i >= 1 && i <= nbits) exp_q.push_back(val[12-i]);
      else                      exp_q.push_back(1'b0);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge FAB_CLK);
  endtask

  task automatic select(input bit on);
    @(negedge FAB_CLK);
    spi_ss_n = ~on;
    wait_cycles(10);
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int zeros, input int nclk, input bit data_mosi);
    logic [7:0] c;
    c = cmd;
    for (int i = 0; i < zeros + 8; i++) begin
      spi_mosi = (i < zeros) ? 1'b0 : c[7 - (i - zeros)];
      #80 spi_sclk = 1'b1;
      #80 spi_sclk = 1'b0;
    end
    for (int i = 0; i < nclk; i++) begin
      spi_mosi = data_mosi;
      #80;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fails++;
        $error("FAIL miso_queue: got empty expected entry");
      end else begin
        check("miso_bit", {11'd0, spi_miso}, {11'd0, exp_q.pop_front()});
      end
      check("miso_oe_active", {11'd0, spi_miso_oe}, 12'd1);
      spi_sclk = 1'b1;
      #80 spi_sclk = 1'b0;
    end
    spi_mosi = 1'b0;
  endtask

  initial begin
    int unsigned cv0;
    MSS_RESET_N = 1'b0;
    spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    x_pos = 12'hA5C; y_pos = 12'h3F1; z1_val = 12'h123; z2_val = 12'h7FF;
    pen_down = 1'b0;
    wait_cycles(5);
    check("rst_miso", {11'd0, spi_miso}, 12'd0);
    check("rst_oe", {11'd0, spi_miso_oe}, 12'd0);
    check("rst_pen_irq_n", {11'd0, pen_irq_n}, 12'd1);
    check("rst_cmd_valid", {11'd0, cmd_valid}, 12'd0);
    check("rst_cmd_byte", {4'd0, cmd_byte}, 12'h000);
    MSS_RESET_N = 1'b1;
    wait_cycles(5);
    check("idle_pen_irq_n", {11'd0, pen_irq_n}, 12'd1);

    // 1: 12-bit X read; MOSI held high in DATA must not start a new command
    cv0 = cv_cnt;
    select(1);
    push_expected(x_pos, 1'b0, 16);
    spi_frame(8'hD0, 0, 16, 1'b1);
    select(0);
    check("t1_cmd_valid_pulses", 12'(cv_cnt - cv0), 12'd1);
    check("t1_cmd_byte", {4'd0, cmd_byte}, 12'h0D0);
    check("t1_gap_oe", {11'd0, spi_miso_oe}, 12'd0);

    // 2: 8-bit Y read
    cv0 = cv_cnt;
    select(1);
    push_expected(y_pos, 1'b1, 16);
    spi_frame(8'h98, 0, 16, 1'b0);
    select(0);
    check("t2_cmd_valid_pulses", 12'(cv_cnt - cv0), 12'd1);
    check("t2_cmd_byte", {4'd0, cmd_byte}, 12'h098);

    // 3: leading zeros before Z1 command
    select(1);
    push_expected(z1_val, 1'b0, 16);
    spi_frame(8'hB0, 3, 16, 1'b0);
    select(0);
    check("t3_cmd_byte", {4'd0, cmd_byte}, 12'h0B0);

    // 4: abort after 4 data bits, then Z2 read
    select(1);
    push_expected(x_pos, 1'b0, 4);
    spi_frame(8'hD0, 0, 4, 1'b0);
    select(0);
    check("t4_gap_oe", {11'd0, spi_miso_oe}, 12'd0);
    check("t4_gap_miso", {11'd0, spi_miso}, 12'd0);
    cv0 = cv_cnt;
    select(1);
    push_expected(z2_val, 1'b0, 16);
    spi_frame(8'hC0, 0, 16, 1'b0);
    select(0);
    check("t4_cmd_valid_pulses", 12'(cv_cnt - cv0), 12'd1);
    check("t4_cmd_byte", {4'd0, cmd_byte}, 12'h0C0);

    // 5: pen interrupt gated by power-down mode
    pen_down = 1'b1;
    wait_cycles(6);
    check("t5_pen_irq_active", {11'd0, pen_irq_n}, 12'd0);
    select(1);
    push_expected(x_pos, 1'b0, 16);
    spi_frame(8'hD3, 0, 16, 1'b0);
    select(0);
    check("t5_pen_irq_pd11", {11'd0, pen_irq_n}, 12'd1);
    select(1);
    push_expected(x_pos, 1'b0, 16);
    spi_frame(8'hD0, 0, 16, 1'b0);
    select(0);
    check("t5_pen_irq_pd00", {11'd0, pen_irq_n}, 12'd0);

    // 6: reset in the middle of DATA
    select(1);
    push_expected(x_pos, 1'b0, 5);
    spi_frame(8'hD0, 0, 5, 1'b0);
    check("t6_pen_irq_in_data", {11'd0, pen_irq_n}, 12'd1);
    @(negedge FAB_CLK);
    MSS_RESET_N = 1'b0;
    @(posedge FAB_CLK);
    #1;
    check("t6_rst_miso", {11'd0, spi_miso}, 12'd0);
    check("t6_rst_oe", {11'd0, spi_miso_oe}, 12'd0);
    check("t6_rst_pen_irq_n", {11'd0, pen_irq_n}, 12'd1);
    check("t6_rst_cmd_valid", {11'd0, cmd_valid}, 12'd0);
    check("t6_rst_cmd_byte", {4'd0, cmd_byte}, 12'h000);
    @(negedge FAB_CLK);
    MSS_RESET_N = 1'b1;
    select(0);
    x_pos = 12'h5A3;
    cv0 = cv_cnt;
    select(1);
    push_expected(x_pos, 1'b0, 16);
    spi_frame(8'hD0, 0, 16, 1'b0);
    select(0);
    check("t6_cmd_valid_pulses", 12'(cv_cnt - cv0), 12'd1);
    check("t6_cmd_byte", {4'd0, cmd_byte}, 12'h0D0);
    check("queue_drained", 12'(exp_q.size()), 12'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
